mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL expose parameter FETCH_INC, default 4, PC increment selected by ALUSrcB=01.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 opcode  input  7  instruction opcode from instruction register (IR[6:0]).
REQ-005 zero  input  1  ALU zero flag from the branch-compare cycle.
REQ-006 mem_ready  input  1  memory done/accept for the current mem_req.
REQ-007 mem_req  output  1  memory access request; held until mem_ready.
REQ-008 MemRead / MemWrite  output  1 each  memory direction qualifiers.
REQ-009 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 IRWrite / PCWrite / RegWrite / MemToReg / PCSrc  output  1 each  datapath enables/selects (PCSrc: 0=ALU result, 1=ALUOut).
REQ-011 ALUSrcA  output  2  00=PC, 01=rs1, 10=oldPC.
REQ-012 ALUSrcB  output  2  00=rs2, 01=FETCH_INC, 10=immediate.
REQ-013 ALUOp  output  2  to alu_control: 00=ADD, 01=SUB, 10=funct3/funct7 decode; 11 never driven.
REQ-014 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-015 state  output  4  current FSM state encoding (debug).

Function
REQ-016 FSM states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH; Moore outputs except enables gated by mem_ready/zero as stated.
REQ-017 Outputs not listed for a state SHALL be 0 (ALUSrcA/B/ALUOp default 00).
REQ-018 FETCH: mem_req=1, MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go DECODE.
REQ-019 DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target); next by opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADDR, 1100011->BRANCH, other->FETCH with illegal=1 this cycle.
REQ-020 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10 -> WB_ALU.
REQ-021 EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ADDI only) -> WB_ALU.
REQ-022 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00 -> MEM_RD if opcode=0000011, MEM_WR if 0100011.
REQ-023 MEM_RD: mem_req=1, MemRead=1, IorD=1; stay until mem_ready=1, then WB_MEM.
REQ-024 MEM_WR: mem_req=1, MemWrite=1, IorD=1; stay until mem_ready=1, then FETCH.
REQ-025 WB_ALU: RegWrite=1, MemToReg=0 -> FETCH. WB_MEM: RegWrite=1, MemToReg=1 -> FETCH.
REQ-026 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=zero -> FETCH.
REQ-027 Latency (mem_ready=1 immediately): R/I=4 cycles, LW=5, SW=4, BEQ=3, illegal=2.
REQ-028 opcode SHALL be treated as stable from DECODE to instruction end; FSM SHALL not re-sample mid-instruction beyond REQ-019/022.
REQ-029 mem_req, MemRead/MemWrite, IorD SHALL stay constant while waiting on mem_ready; no enable asserts twice per instruction.
REQ-030 Unreachable state encodings SHALL transition to FETCH next cycle with all outputs 0.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force FETCH next cycle regardless of current state, including mid memory wait.
REQ-032 While rst_n=0 all enables, mem_req, illegal SHALL be 0 and state=FETCH encoding (0000); first fetch request issues on the first cycle after rst_n rises.

Structure
REQ-033 State encodings (FETCH=0 ... BRANCH=9), opcode constants, ALUOp codes, ALUSrcA/B codes SHALL live in a shared package used also by alu_control and the datapath.
REQ-034 Single module; state register plus combinational next-state/output logic; no sub-module.

Verification
REQ-035 R-type ADD (opcode 0110011), mem_ready=1 -> states FETCH,DECODE,EXEC_R(ALUOp=10),WB_ALU(RegWrite=1), back to FETCH cycle 5.
REQ-036 LW (0000011), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_req/MemRead/IorD=1 steady, then WB_MEM MemToReg=1.
REQ-037 BEQ zero=1 -> BRANCH ALUOp=01, PCSrc=1, PCWrite=1; zero=0 -> PCWrite=0; both return to FETCH.
REQ-038 opcode 1111111 -> illegal=1 for DECODE cycle only, next state FETCH, no RegWrite/MemWrite.
REQ-039 rst_n=0 during MEM_WR wait -> FETCH next cycle, MemWrite=0, mem_req=0 until rst_n=1.
REQ-040 FETCH with mem_ready=0 for 4 cycles -> IRWrite/PCWrite=0 throughout, pulse exactly once on mem_ready=1.

Source files
------------

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle controller
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_INC = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // S_FETCH doubles as the "unsupported opcode" answer.
  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_R:         return S_EXEC_R;
      OP_I:         return S_EXEC_I;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ:       return S_BRANCH;
      default:      return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - memory request/ready handshake between controller and memory port
interface mc_control_if;
  logic mem_req;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output MemRead, output MemWrite, output IorD, input mem_ready);
  modport slave  (input mem_req, input MemRead, input MemWrite, input IorD, output mem_ready);
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle RISC-V style control FSM (fetch/decode/execute/memory/writeback)
module mc_control
  import mc_control_pkg::*;
#(
  parameter int FETCH_INC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                zero,
  mc_control_if.master        mem,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemToReg,
  output logic                PCSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                illegal,
  output logic [3:0]          state
);

  if (FETCH_INC <= 0) begin : g_bad_fetch_inc
    $error("mc_control: FETCH_INC must be positive");
  end

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_INC;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem.mem_ready;
        ctrl.pc_write  = mem.mem_ready;
        state_d        = mem.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU speculatively forms the branch target from the old PC.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = decode_next(opcode);
        ctrl.illegal   = (decode_next(opcode) == S_FETCH);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = mem.mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        state_d        = mem.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = zero;
        state_d        = S_FETCH;
      end
      default: begin
        ctrl    = '0;
        state_d = S_FETCH;
      end
    endcase
    // Outputs are held quiet for the whole reset window, not just after the first edge.
    if (!rst_n) ctrl = '0;
  end

  assign mem.mem_req  = ctrl.mem_req;
  assign mem.MemRead  = ctrl.mem_read;
  assign mem.MemWrite = ctrl.mem_write;
  assign mem.IorD     = ctrl.iord;
  assign IRWrite      = ctrl.ir_write;
  assign PCWrite      = ctrl.pc_write;
  assign RegWrite     = ctrl.reg_write;
  assign MemToReg     = ctrl.mem_to_reg;
  assign PCSrc        = ctrl.pc_src;
  assign ALUSrcA      = ctrl.alu_src_a;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign ALUOp        = ctrl.alu_op;
  assign illegal      = ctrl.illegal;
  assign state        = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - cycle-by-cycle check of mc_control against an instruction-level trace model
module tb_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       rd;
    logic       wr;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       m2r;
    logic       pcsrc;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic       ill;
  } exp_t;

  typedef struct {
    string      tag;
    logic       rst_n;
    logic [6:0] opc;
    logic       rdy;
    logic       z;
    exp_t       e;
  } cyc_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       IRWrite, PCWrite, RegWrite, MemToReg, PCSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  mc_control_if mif ();

  mc_control #(.FETCH_INC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .zero     (zero),
    .mem      (mif),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .PCSrc    (PCSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .illegal  (illegal),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cyc_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic is_legal(input logic [6:0] o);
    return (o == 7'b0110011) || (o == 7'b0010011) || (o == 7'b0000011) ||
           (o == 7'b0100011) || (o == 7'b1100011);
  endfunction

  function automatic cyc_t blank(input string tag, input logic [6:0] opc, input logic z);
    cyc_t c;
    c.tag   = tag;
    c.rst_n = 1'b1;
    c.opc   = opc;
    c.rdy   = 1'($urandom_range(0, 1));
    c.z     = z;
    c.e     = '0;
    return c;
  endfunction

  task automatic add_reset(input string tag, input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c       = blank(tag, 7'($urandom), 1'($urandom_range(0, 1)));
      c.rst_n = 1'b0;
      q.push_back(c);
    end
  endtask

  // One instruction as the sequence of cycles the datapath should see.
  task automatic add_instr(input string tag, input logic [6:0] opc, input logic z,
                           input int fetch_wait, input int mem_wait, input int stop_after_memwait);
    cyc_t c;
    for (int k = 0; k <= fetch_wait; k++) begin
      c = blank(tag, opc, z);
      c.rdy = (k == fetch_wait);
      c.e.st = 4'd0; c.e.mem_req = 1; c.e.rd = 1; c.e.sb = 2'b01;
      c.e.irw = c.rdy; c.e.pcw = c.rdy;
      q.push_back(c);
    end
    c = blank(tag, opc, z);
    c.e.st = 4'd1; c.e.sa = 2'b10; c.e.sb = 2'b10; c.e.ill = !is_legal(opc);
    q.push_back(c);
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      c = blank(tag, opc, z);
      c.e.sa = 2'b01;
      if (opc == 7'b0110011) begin c.e.st = 4'd2; c.e.sb = 2'b00; c.e.op = 2'b10; end
      else                   begin c.e.st = 4'd3; c.e.sb = 2'b10; end
      q.push_back(c);
      c = blank(tag, opc, z);
      c.e.st = 4'd7; c.e.rw = 1;
      q.push_back(c);
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      c = blank(tag, opc, z);
      c.e.st = 4'd4; c.e.sa = 2'b01; c.e.sb = 2'b10;
      q.push_back(c);
      for (int k = 0; k <= mem_wait; k++) begin
        if (stop_after_memwait != 0 && k == mem_wait) return;
        c = blank(tag, opc, z);
        c.rdy = (k == mem_wait);
        c.e.mem_req = 1; c.e.iord = 1;
        if (opc == 7'b0000011) begin c.e.st = 4'd5; c.e.rd = 1; end
        else                   begin c.e.st = 4'd6; c.e.wr = 1; end
        q.push_back(c);
      end
      if (opc == 7'b0000011) begin
        c = blank(tag, opc, z);
        c.e.st = 4'd8; c.e.rw = 1; c.e.m2r = 1;
        q.push_back(c);
      end
    end else if (opc == 7'b1100011) begin
      c = blank(tag, opc, z);
      c.e.st = 4'd9; c.e.sa = 2'b01; c.e.sb = 2'b00; c.e.op = 2'b01;
      c.e.pcsrc = 1; c.e.pcw = z;
      q.push_back(c);
    end
  endtask

  function automatic exp_t sample();
    exp_t a;
    a.st = state; a.mem_req = mif.mem_req; a.rd = mif.MemRead; a.wr = mif.MemWrite;
    a.iord = mif.IorD; a.irw = IRWrite; a.pcw = PCWrite; a.rw = RegWrite;
    a.m2r = MemToReg; a.pcsrc = PCSrc; a.sa = ALUSrcA; a.sb = ALUSrcB;
    a.op = ALUOp; a.ill = illegal;
    return a;
  endfunction

  task automatic run_queue();
    exp_t act;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst_n         = q[i].rst_n;
      opcode        = q[i].opc;
      mif.mem_ready = q[i].rdy;
      zero          = q[i].z;
      #1;
      act = sample();
      checks++;
      if (act !== q[i].e) begin
        errors++;
        $display("FAIL %s step %0d: got %h want %h (st/req/rd/wr/iord/irw/pcw/rw/m2r/pcsrc/sa/sb/op/ill)",
                 q[i].tag, i, act, q[i].e);
      end
    end
    q.delete();
  endtask

  initial begin
    logic [6:0] r_opc;
    int         cls;
    rst_n = 1'b0;
    opcode = 7'd0;
    zero = 1'b0;
    mif.mem_ready = 1'b1;

    add_reset("reset", 3);
    add_instr("r_add", 7'b0110011, 1'b0, 0, 0, 0);
    add_instr("lw_wait2", 7'b0000011, 1'b0, 0, 2, 0);
    add_instr("beq_z1", 7'b1100011, 1'b1, 0, 0, 0);
    add_instr("beq_z0", 7'b1100011, 1'b0, 0, 0, 0);
    add_instr("illegal_7f", 7'b1111111, 1'b0, 0, 0, 0);
    add_instr("sw", 7'b0100011, 1'b0, 0, 0, 0);
    add_instr("addi", 7'b0010011, 1'b0, 0, 0, 0);
    add_instr("fetch_wait4", 7'b0110011, 1'b0, 4, 0, 0);
    add_instr("sw_reset_mid", 7'b0100011, 1'b0, 0, 2, 1);
    add_reset("sw_reset_mid", 2);
    add_instr("after_reset", 7'b0000011, 1'b0, 0, 0, 0);
    run_queue();

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 5);
      case (cls)
        0: r_opc = 7'b0110011;
        1: r_opc = 7'b0010011;
        2: r_opc = 7'b0000011;
        3: r_opc = 7'b0100011;
        4: r_opc = 7'b1100011;
        default: begin
          r_opc = 7'($urandom);
          if (is_legal(r_opc)) r_opc = 7'b1111111;
        end
      endcase
      add_instr("random", r_opc, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
